// File: rtl/hex_serializer_pkg.sv
// Shared types and constants for the hex text streamer.
package hex_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } state_e;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_X  = 8'h78;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  // A one-nibble word still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/hex_serializer_nibble_to_ascii.sv
// Combinational map of one nibble to its uppercase ASCII hex digit.
module nibble_to_ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] char_o
);

  always_comb begin
    if (nib_i < 4'd10) char_o = 8'h30 + {4'h0, nib_i};
    else               char_o = 8'h37 + {4'h0, nib_i};
  end

endmodule

// File: rtl/hex_serializer.sv
// Streams a latched WIDTH-bit word as ASCII hex text, MS nibble first,
// with optional "0x" prefix, leading-zero suppression and CR LF terminator.
//
// state    | meaning
// ST_IDLE  | waiting for a word, in_ready high
// ST_PFX0  | presenting "0"
// ST_PFX1  | presenting "x"
// ST_DIGIT | presenting nibble[idx]
// ST_CR    | presenting carriage return
// ST_LF    | presenting line feed (final character)
module hex_serializer
  import hex_serializer_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int PREFIX         = 0,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int NEWLINE        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_char_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = idx_width(NIB);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    lead_idx, start_idx;
  logic [3:0]       cur_nib;
  logic [7:0]       digit_char;
  logic             accept, out_hs;

  assign in_ready_o  = (state_q == ST_IDLE) && !rst;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q != ST_IDLE);
  assign out_hs      = out_valid_o && out_ready_i;
  assign busy_o      = (state_q != ST_IDLE);

  // Highest nonzero nibble of the incoming word; a zero word yields 0.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < NIB; i++) begin
      if (in_data_i[i*4 +: 4] != 4'h0) lead_idx = IW'(i);
    end
  end

  assign start_idx = (SUPPRESS_ZEROS != 0) ? lead_idx : IW'(NIB - 1);

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) cur_nib = shreg_q[i*4 +: 4];
    end
  end

  nibble_to_ascii u_n2a (
    .nib_i  (cur_nib),
    .char_o (digit_char)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = in_data_i;
          idx_d   = start_idx;
          state_d = (PREFIX != 0) ? ST_PFX0 : ST_DIGIT;
        end
      end
      ST_PFX0: if (out_hs) state_d = ST_PFX1;
      ST_PFX1: if (out_hs) state_d = ST_DIGIT;
      ST_DIGIT: begin
        if (out_hs) begin
          if (idx_q == '0) state_d = (NEWLINE != 0) ? ST_CR : ST_IDLE;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      ST_CR:   if (out_hs) state_d = ST_LF;
      ST_LF:   if (out_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode only registered state, so they hold through any stall.
  always_comb begin
    case (state_q)
      ST_PFX0:  out_char_o = CHAR_0;
      ST_PFX1:  out_char_o = CHAR_X;
      ST_DIGIT: out_char_o = digit_char;
      ST_CR:    out_char_o = CHAR_CR;
      ST_LF:    out_char_o = CHAR_LF;
      default:  out_char_o = 8'h00;
    endcase
  end

  assign out_last_o = (state_q == ST_LF) ||
                      ((state_q == ST_DIGIT) && (idx_q == '0) && (NEWLINE == 0));

endmodule

// File: tb/tb_hex_serializer.sv
// Directed bench for hex_serializer across four parameter configurations.
module tb_hex_serializer;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  wire  [3:0]  in_ready, out_valid, out_last, busy;
  wire  [7:0]  out_char [4];
  logic [15:0] d0, d1;
  logic [31:0] d2;
  logic [3:0]  d3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          n;
    logic [63:0] chars;
  } vec_t;

  vec_t vecs [12];

  hex_serializer #(.WIDTH(16)) u_def (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(d0), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_char_o(out_char[0]), .out_last_o(out_last[0]), .busy_o(busy[0]));

  hex_serializer #(.WIDTH(16), .PREFIX(1), .SUPPRESS_ZEROS(1), .NEWLINE(1)) u_full (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(d1), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_char_o(out_char[1]), .out_last_o(out_last[1]), .busy_o(busy[1]));

  hex_serializer #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_data_i(d2), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .out_char_o(out_char[2]), .out_last_o(out_last[2]), .busy_o(busy[2]));

  hex_serializer #(.WIDTH(4), .SUPPRESS_ZEROS(1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
    .in_data_i(d3), .out_valid_o(out_valid[3]), .out_ready_i(out_ready[3]),
    .out_char_o(out_char[3]), .out_last_o(out_last[3]), .busy_o(busy[3]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] data);
    case (d)
      0: begin in_valid[0] = v; d0 = data[15:0]; end
      1: begin in_valid[1] = v; d1 = data[15:0]; end
      2: begin in_valid[2] = v; d2 = data; end
      default: begin in_valid[3] = v; d3 = data[3:0]; end
    endcase
  endtask

  // Accept one word with out_ready high and check every character cycle by cycle.
  task automatic run_word(input int d, input logic [31:0] data, input int n,
                          input logic [63:0] chars, input string nm);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("%s in_ready", nm), 64'(in_ready[d]), 64'(1));
    drive(d, 1'b1, data);
    @(negedge clk);
    drive(d, 1'b0, data);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s valid%0d", nm, k), 64'(out_valid[d]), 64'(1));
      chk($sformatf("%s char%0d", nm, k), 64'(out_char[d]), 64'(chars[8*(n-1-k) +: 8]));
      chk($sformatf("%s last%0d", nm, k), 64'(out_last[d]), 64'(k == n - 1));
    end
    @(negedge clk);
    chk($sformatf("%s done_valid", nm), 64'(out_valid[d]), 64'(0));
    chk($sformatf("%s done_ready", nm), 64'(in_ready[d]), 64'(1));
  endtask

  initial begin
    logic [7:0]  got [$];
    logic [7:0]  held;
    logic        stalled;
    logic [31:0] bp_exp;
    int          cyc;
    logic [7:0]  exp_c;

    vecs[0]  = '{0, 32'h1A2F, 4, 64'("1A2F")};
    vecs[1]  = '{0, 32'h0000, 4, 64'("0000")};
    vecs[2]  = '{0, 32'hFFFF, 4, 64'("FFFF")};
    vecs[3]  = '{0, 32'h0009, 4, 64'("0009")};
    vecs[4]  = '{1, 32'h00B3, 6, 64'({"0xB3", CR, LF})};
    vecs[5]  = '{1, 32'h0000, 5, 64'({"0x0", CR, LF})};
    vecs[6]  = '{1, 32'h1000, 8, 64'({"0x1000", CR, LF})};
    vecs[7]  = '{1, 32'h000F, 5, 64'({"0xF", CR, LF})};
    vecs[8]  = '{2, 32'hDEADBEEF, 8, 64'("DEADBEEF")};
    vecs[9]  = '{2, 32'h00000001, 8, 64'("00000001")};
    vecs[10] = '{3, 32'h0, 1, 64'("0")};
    vecs[11] = '{3, 32'hA, 1, 64'("A")};

    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst in_ready%0d", d), 64'(in_ready[d]), 64'(0));
      chk($sformatf("rst out_valid%0d", d), 64'(out_valid[d]), 64'(0));
      chk($sformatf("rst busy%0d", d), 64'(busy[d]), 64'(0));
      chk($sformatf("rst out_char%0d", d), 64'(out_char[d]), 64'(0));
      chk($sformatf("rst out_last%0d", d), 64'(out_last[d]), 64'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      chk($sformatf("post-rst in_ready%0d", d), 64'(in_ready[d]), 64'(1));

    for (int v = 0; v < 12; v++)
      run_word(vecs[v].dut, vecs[v].data, vecs[v].n, vecs[v].chars, $sformatf("vec%0d", v));

    // Backpressure on 16'hC0DE, with out_ready low when the first character appears.
    bp_exp = "C0DE";
    @(negedge clk);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 32'hC0DE);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    stalled = 1'b0;
    held = '0;
    cyc = 0;
    while (got.size() < 4 && cyc < 200) begin
      if (stalled) chk("bp stable", 64'(out_char[0]), 64'(held));
      if (cyc < 3) out_ready[0] = 1'b0;
      else         out_ready[0] = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (out_valid[0]) begin
        if (out_ready[0]) got.push_back(out_char[0]);
        else begin
          stalled = 1'b1;
          held = out_char[0];
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready[0] = 1'b1;
    chk("bp count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("bp char%0d", i), 64'(got[i]), 64'(bp_exp[8*(3-i) +: 8]));
    chk("bp no_dup", 64'(out_valid[0]), 64'(0));

    // Reset in the middle of 16'h1234.
    @(negedge clk);
    drive(0, 1'b1, 32'h1234);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    chk("mid char0", 64'(out_char[0]), 64'("1"));
    @(negedge clk);
    chk("mid char1", 64'(out_char[0]), 64'("2"));
    @(negedge clk);
    chk("mid char2", 64'(out_char[0]), 64'("3"));
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst valid", 64'(out_valid[0]), 64'(0));
    chk("mid rst busy", 64'(busy[0]), 64'(0));
    chk("mid rst ready", 64'(in_ready[0]), 64'(0));
    chk("mid rst char", 64'(out_char[0]), 64'(0));
    @(negedge clk);
    chk("mid rst ready2", 64'(in_ready[0]), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid after valid", 64'(out_valid[0]), 64'(0));
    chk("mid after ready", 64'(in_ready[0]), 64'(1));
    run_word(0, 32'h5678, 4, 64'("5678"), "after_rst");

    // in_valid held high across two words; the second waits for the first to drain.
    drive(0, 1'b1, 32'hAAAA);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b1, 32'hBBBB);
      if (k == 9) drive(0, 1'b0, 32'hBBBB);
      if (k < 5)                exp_c = "A";
      else if (k > 5 && k < 10) exp_c = "B";
      else                      exp_c = 8'h00;
      chk($sformatf("busy valid%0d", k), 64'(out_valid[0]), 64'(k != 5 && k != 10));
      chk($sformatf("busy char%0d", k), 64'(out_char[0]), 64'(exp_c));
      chk($sformatf("busy last%0d", k), 64'(out_last[0]), 64'(k == 4 || k == 9));
      chk($sformatf("busy ready%0d", k), 64'(in_ready[0]), 64'(k == 5 || k == 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
